// File: rtl/fractal_worker.sv
// fractal_worker: computes the escape-time iteration count and pixel colour
// for one screen coordinate, for either a Julia or a Mandelbrot set, and
// presents colour/address to a memory controller until it acknowledges.
module fractal_worker #(
  parameter int          FRACTIONAL   = 11,
  parameter int          INTEGRAL     = 11,
  parameter int          WIDTH        = INTEGRAL + FRACTIONAL,
  parameter int          ITER_BITS    = 8,
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          PIXEL_BYTES  = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h08000000,
  parameter logic [31:0] INSIDE_COLOR = 32'h00000000
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    JW_start,
  input  logic                    MC_done,
  input  logic                    mode,
  input  logic [ITER_BITS-1:0]    max_iter,
  input  logic signed [WIDTH-1:0] c_real_in,
  input  logic signed [WIDTH-1:0] c_imag_in,
  input  logic signed [WIDTH-1:0] origin_real,
  input  logic signed [WIDTH-1:0] origin_imag,
  input  logic signed [WIDTH-1:0] step,
  output logic                    JW_ready,
  output logic                    JW_done,
  output logic [31:0]             color,
  output logic [31:0]             address,
  output logic [ITER_BITS-1:0]    iter_count
);

  typedef enum logic [1:0] {IDLE, MAP, ITER, WRITE} state_t;

  localparam int MAG_W = 2 * WIDTH + 1;
  localparam logic signed [WIDTH-1:0] HALF_W = WIDTH'(SCREEN_W / 2);
  localparam logic signed [WIDTH-1:0] HALF_H = WIDTH'(SCREEN_H / 2);
  // |z|^2 escape bound: 4.0 expressed at the scale of a full product.
  localparam logic [MAG_W-1:0] MAG_LIMIT = MAG_W'(4) << (2 * FRACTIONAL);

  state_t r_state, w_state_next;

  // Job parameters captured at acceptance.
  logic [9:0]              r_x, r_y;
  logic                    r_mode;
  logic [ITER_BITS-1:0]    r_max_iter;
  logic signed [WIDTH-1:0] r_org_r, r_org_i, r_step;
  // Iteration state.
  logic signed [WIDTH-1:0] r_zr, r_zi, r_cr, r_ci;
  logic [ITER_BITS-1:0]    r_iter;
  // Result registers.
  logic [31:0]             r_color, r_address;
  logic [ITER_BITS-1:0]    r_iter_count;

  // Pixel-to-plane mapping (products wrap to WIDTH bits).
  logic signed [WIDTH-1:0] w_xoff, w_yoff, w_pr, w_pi;
  assign w_xoff = $signed({{(WIDTH-10){1'b0}}, r_x}) - HALF_W;
  assign w_yoff = $signed({{(WIDTH-10){1'b0}}, r_y}) - HALF_H;
  assign w_pr   = r_org_r + w_xoff * r_step;
  assign w_pi   = r_org_i - w_yoff * r_step;

  // Full-precision squares and cross term; magnitude is never truncated.
  logic signed [2*WIDTH-1:0] w_sq_r, w_sq_i, w_cross;
  logic [MAG_W-1:0]          w_mag;
  logic signed [WIDTH-1:0]   w_zr_next, w_zi_next;
  logic                      w_escape, w_limit;
  assign w_sq_r    = r_zr * r_zr;
  assign w_sq_i    = r_zi * r_zi;
  assign w_cross   = r_zr * r_zi;
  assign w_mag     = {1'b0, w_sq_r} + {1'b0, w_sq_i};
  assign w_escape  = (w_mag > MAG_LIMIT);
  assign w_limit   = (r_iter == r_max_iter);
  assign w_zr_next = WIDTH'((w_sq_r - w_sq_i) >>> FRACTIONAL) + r_cr;
  assign w_zi_next = WIDTH'((w_cross <<< 1) >>> FRACTIONAL) + r_ci;

  // Escape colour palette and frame-buffer address.
  logic [7:0]  w_n;
  logic [31:0] w_iter_color, w_addr;
  assign w_n          = 8'(r_iter);
  assign w_iter_color = {8'h00, w_n, ~w_n, w_n[3:0], 4'h0};
  assign w_addr       = BASE_ADDR
                      + ((32'(r_y) * 32'(SCREEN_W)) + 32'(r_x)) * 32'(PIXEL_BYTES);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; escape/limit ends ITER, MC_done ends WRITE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (JW_start) w_state_next = MAP;
      MAP:     w_state_next = ITER;
      ITER:    if (w_escape || w_limit) w_state_next = WRITE;
      WRITE:   if (MC_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: latch job, seed z/c, iterate, capture result on exit from ITER.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_mode       <= 1'b0;
      r_max_iter   <= '0;
      r_org_r      <= '0;
      r_org_i      <= '0;
      r_step       <= '0;
      r_zr         <= '0;
      r_zi         <= '0;
      r_cr         <= '0;
      r_ci         <= '0;
      r_iter       <= '0;
      r_color      <= '0;
      r_address    <= '0;
      r_iter_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (JW_start) begin
          r_x        <= x;
          r_y        <= y;
          r_mode     <= mode;
          r_max_iter <= max_iter;
          r_cr       <= c_real_in;
          r_ci       <= c_imag_in;
          r_org_r    <= origin_real;
          r_org_i    <= origin_imag;
          r_step     <= step;
        end
        MAP: begin
          r_iter <= '0;
          if (r_mode) begin
            r_zr <= '0;
            r_zi <= '0;
            r_cr <= w_pr;
            r_ci <= w_pi;
          end else begin
            r_zr <= w_pr;
            r_zi <= w_pi;
          end
        end
        ITER: if (w_escape || w_limit) begin
          r_iter_count <= r_iter;
          r_color      <= w_escape ? w_iter_color : INSIDE_COLOR;
          r_address    <= w_addr;
        end else begin
          r_zr   <= w_zr_next;
          r_zi   <= w_zi_next;
          r_iter <= r_iter + ITER_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  assign JW_ready   = (r_state == IDLE);
  assign JW_done    = (r_state == WRITE);
  assign color      = r_color;
  assign address    = r_address;
  assign iter_count = r_iter_count;

endmodule

// File: tb/tb_fractal_worker.sv
// Directed testbench for fractal_worker: hand-computed jobs, latency,
// handshake corner cases and asynchronous reset.
module tb_fractal_worker;
  localparam int W = 22;

  logic                clk = 1'b0;
  logic                n_rst = 1'b1;
  logic [9:0]          x = '0, y = '0;
  logic                JW_start = 1'b0, MC_done = 1'b0, mode = 1'b0;
  logic [7:0]          max_iter = '0;
  logic signed [W-1:0] c_real_in = '0, c_imag_in = '0;
  logic signed [W-1:0] origin_real = '0, origin_imag = '0, step = '0;
  logic                JW_ready, JW_done;
  logic [31:0]         color, address;
  logic [7:0]          iter_count;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  fractal_worker dut (
    .clk(clk), .n_rst(n_rst), .x(x), .y(y), .JW_start(JW_start),
    .MC_done(MC_done), .mode(mode), .max_iter(max_iter),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in),
    .origin_real(origin_real), .origin_imag(origin_imag), .step(step),
    .JW_ready(JW_ready), .JW_done(JW_done), .color(color),
    .address(address), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input logic m, input logic [9:0] px, input logic [9:0] py,
                         input logic [7:0] mi, input logic [W-1:0] cr, input logic [W-1:0] ci,
                         input logic [W-1:0] orr, input logic [W-1:0] ori, input logic [W-1:0] st);
    mode = m; x = px; y = py; max_iter = mi;
    c_real_in = cr; c_imag_in = ci; origin_real = orr; origin_imag = ori; step = st;
  endtask

  // Called at a negedge; returns edges from the accepting edge to JW_done.
  // poke >= 0 raises JW_start (with a different x) for one cycle mid-job.
  task automatic run_job(input int poke, output int l);
    JW_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    JW_start = 1'b0;
    l = 0;
    while (!JW_done && l < 400) begin
      if (l == poke) begin
        JW_start = 1'b1;
        x = 10'd5;
      end else begin
        JW_start = 1'b0;
      end
      @(posedge clk);
      l++;
      @(negedge clk);
    end
    JW_start = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    MC_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MC_done = 1'b0;
    check({tag, "_ready_after_mc"}, 32'(JW_ready), 32'd1);
    check({tag, "_done_after_mc"}, 32'(JW_done), 32'd0);
  endtask

  initial begin
    #2 n_rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(JW_ready), 32'd1);
    check("rst_done", 32'(JW_done), 32'd0);
    check("rst_color", color, 32'h0);
    check("rst_addr", address, 32'h0);
    check("rst_iter", 32'(iter_count), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // MC_done while idle is ignored.
    MC_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MC_done = 1'b0;
    check("idle_mc_ready", 32'(JW_ready), 32'd1);
    check("idle_mc_done", 32'(JW_done), 32'd0);

    // z stays at 0: runs to the limit.
    set_job(1'b0, 10'd320, 10'd240, 8'd10, '0, '0, '0, '0, '0);
    run_job(-1, lat);
    check("a_latency", 32'(lat), 32'd12);
    check("a_iter", 32'(iter_count), 32'd10);
    check("a_color", color, 32'h0);
    check("a_addr", address, 32'h08096500);
    check("a_ready_in_write", 32'(JW_ready), 32'd0);
    finish_job("a");

    // z0 = 3.0 escapes immediately (back-to-back start).
    set_job(1'b0, 10'd0, 10'd0, 8'd255, '0, '0, 22'h001800, '0, '0);
    run_job(-1, lat);
    check("b_latency", 32'(lat), 32'd2);
    check("b_iter", 32'(iter_count), 32'd0);
    check("b_color", color, 32'h0000FF00);
    finish_job("b");

    // c = 1.0: z = 0,1,2,5 -> escape at 3; then hold in WRITE.
    set_job(1'b0, 10'd5, 10'd2, 8'd255, 22'h000800, '0, '0, '0, '0);
    run_job(-1, lat);
    check("c_latency", 32'(lat), 32'd5);
    check("c_iter", 32'(iter_count), 32'd3);
    check("c_color", color, 32'h0003FC30);
    check("c_addr", address, 32'h08001414);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("c_hold_done", 32'(JW_done), 32'd1);
      check("c_hold_color", color, 32'h0003FC30);
      check("c_hold_addr", address, 32'h08001414);
    end
    // MC_done and JW_start on the same edge: back to idle, no job taken.
    MC_done = 1'b1;
    JW_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MC_done = 1'b0;
    JW_start = 1'b0;
    check("c_mc_start_ready", 32'(JW_ready), 32'd1);
    check("c_mc_start_done", 32'(JW_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("c_no_job_ready", 32'(JW_ready), 32'd1);

    // Mandelbrot c = -2.0: |z|^2 settles at exactly 4, never escapes.
    // A JW_start mid-ITER (with x=5) must be ignored.
    set_job(1'b1, 10'd0, 10'd0, 8'd20, '0, '0, 22'h3FF000, '0, '0);
    run_job(3, lat);
    check("d_latency", 32'(lat), 32'd22);
    check("d_iter", 32'(iter_count), 32'd20);
    check("d_color", color, 32'h0);
    check("d_addr", address, 32'h08000000);
    finish_job("d");

    // max_iter = 0, no escape -> inside.
    set_job(1'b0, 10'd0, 10'd0, 8'd0, '0, '0, '0, '0, '0);
    run_job(-1, lat);
    check("e_latency", 32'(lat), 32'd2);
    check("e_iter", 32'(iter_count), 32'd0);
    check("e_color", color, 32'h0);
    finish_job("e");

    // max_iter = 0 with escape: escape colour wins.
    set_job(1'b0, 10'd0, 10'd0, 8'd0, '0, '0, 22'h001800, '0, '0);
    run_job(-1, lat);
    check("f_latency", 32'(lat), 32'd2);
    check("f_color", color, 32'h0000FF00);
    finish_job("f");

    // Mapping with step 0.5: z0 = 1+1i, c = -2i -> escape at 3.
    set_job(1'b0, 10'd322, 10'd238, 8'd255, '0, 22'h3FF000, '0, '0, 22'h000400);
    run_job(-1, lat);
    check("g_latency", 32'(lat), 32'd5);
    check("g_iter", 32'(iter_count), 32'd3);
    check("g_color", color, 32'h0003FC30);
    check("g_addr", address, 32'h08095108);
    finish_job("g");

    // Asynchronous reset mid-ITER clears outputs immediately.
    set_job(1'b1, 10'd0, 10'd0, 8'd200, '0, '0, 22'h3FF000, '0, '0);
    JW_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    JW_start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("r_busy_ready", 32'(JW_ready), 32'd0);
    #2 n_rst = 1'b0;
    #1;
    check("r_ready", 32'(JW_ready), 32'd1);
    check("r_done", 32'(JW_done), 32'd0);
    check("r_color", color, 32'h0);
    check("r_addr", address, 32'h0);
    check("r_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // First job after reset is accepted and runs normally.
    set_job(1'b0, 10'd0, 10'd0, 8'd4, '0, '0, '0, '0, '0);
    run_job(-1, lat);
    check("h_latency", 32'(lat), 32'd6);
    check("h_iter", 32'(iter_count), 32'd4);
    check("h_color", color, 32'h0);
    finish_job("h");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fractal_worker.md
FRACTAL_WORKER -- requirements
Module: fractal_worker

Interface
REQ-001 Params SHALL be: FRACTIONAL 11, fraction bits; INTEGRAL 11, integer bits incl. sign; WIDTH INTEGRAL+FRACTIONAL, operand width; ITER_BITS 8, iteration-count width; SCREEN_W 640; SCREEN_H 480; PIXEL_BYTES 4; BASE_ADDR 32'h08000000; INSIDE_COLOR 32'h00000000.
REQ-002 Ports SHALL be: clk in 1, sole clock; n_rst in 1, asynchronous active-low reset.
REQ-003 x, y in 10 each, pixel coordinates; JW_start in 1, job request; MC_done in 1, memory controller has written the result.
REQ-004 mode in 1 (0 Julia, 1 Mandelbrot); max_iter in ITER_BITS, runtime iteration limit.
REQ-005 c_real_in, c_imag_in, origin_real, origin_imag, step in signed WIDTH, Q(INTEGRAL.FRACTIONAL).
REQ-006 JW_ready out 1, idle; JW_done out 1, result valid; color out 32; address out 32; iter_count out ITER_BITS.

Function
REQ-007 FSM states SHALL be IDLE, MAP, ITER, WRITE; JW_ready=1 only in IDLE, JW_done=1 only in WRITE.
REQ-008 IDLE: JW_start=1 at an edge SHALL latch x, y, mode, max_iter, c_*, origin_*, step and go to MAP; JW_start outside IDLE ignored.
REQ-009 MAP (1 cycle): p_r = origin_real + (x - SCREEN_W/2)*step, p_i = origin_imag - (y - SCREEN_H/2)*step; offset is signed integer, product keeps low WIDTH bits (wrap).
REQ-010 MAP: mode 0 -> z0=p, c=c_in; mode 1 -> z0=0, c=p; iter cleared to 0; next ITER.
REQ-011 ITER, one iteration per cycle: compute full-precision mag = zr*zr + zi*zi (2*WIDTH+1 bits, no truncation).
REQ-012 Escape when mag > (4 << 2*FRACTIONAL) (strictly greater); equal to 4 is not escape.
REQ-013 If escape or iter == max_iter: go WRITE, iter_count = iter, no z update that cycle; escape checked before limit, both same cycle -> escape result.
REQ-014 Else: zr <= ((zr*zr - zi*zi) >>> FRACTIONAL) + cr, zi <= ((2*zr*zi) >>> FRACTIONAL) + ci, arithmetic shift, truncated to WIDTH (wrap); iter++.
REQ-015 Latency: point ending at count k SHALL raise JW_done k+2 edges after the edge sampling JW_start; max_iter=0 -> k=0.
REQ-016 color: iter_count == max_iter and no escape -> INSIDE_COLOR; else {8'h00, n, ~n, n[3:0],4'h0}, n = iter_count[7:0] zero-extended if ITER_BITS<8.
REQ-017 address = BASE_ADDR + (y*SCREEN_W + x)*PIXEL_BYTES, 32-bit wrap, from latched x,y.
REQ-018 color, address, iter_count registered; stable through WRITE.
REQ-019 WRITE: hold until MC_done=1 at an edge, then IDLE; MC_done outside WRITE ignored; MC_done with JW_start same edge: only IDLE next, no job accepted.
REQ-020 Back-to-back: JW_start sampled in first IDLE cycle after WRITE accepted.

Reset
REQ-021 n_rst=0 SHALL, asynchronously and at any state incl. mid-ITER, force IDLE; JW_ready=1, JW_done=0, color=0, address=0, iter_count=0, internal z, c, iter cleared.
REQ-022 After release no job active; first rising edge with JW_start=1 accepts.

Verification
REQ-023 Params default; mode 0, c=0, origin=0, step=0, max_iter=10 -> JW_done 12 edges after start, iter_count=10, color=32'h0.
REQ-024 mode 0, origin_real=0x1800 (3.0), step=0, c=0, max_iter=255 -> escape at 0, JW_done after 2 edges, color=32'h0000FF00.
REQ-025 mode 0, z0=0, c_real=0x0800 (1.0) -> z 0,1,2,5, iter_count=3, JW_done after 5 edges, color=32'h0003FC30; mode 1, origin_real=-2.0 (0x3FF000), step=0 -> |z|^2=4 never escapes, max_iter=20 -> color=INSIDE_COLOR, iter_count=20.
REQ-026 x=5, y=2 -> address=32'h08001414; JW_done held with MC_done=0 for 50 cycles, outputs unchanged; MC_done pulse returns IDLE, JW_ready=1 next cycle.
REQ-027 n_rst low mid-ITER -> immediately JW_ready=1, JW_done=0, outputs 0; JW_start during ITER or MC_done in IDLE has no effect.
